// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the stream UART transmitter.
// Holds parity/state enums, baud divisor and frame length functions.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_e;

    function automatic int baud_div(input longint clk_freq,
                                    input longint baud_rate);
        return int'(clk_freq / baud_rate);
    endfunction

    function automatic int frame_bits(input int      data_bits,
                                      input parity_e parity,
                                      input int      stop_bits);
        return 1 + data_bits + ((parity == PAR_NONE) ? 0 : 1) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO, sync active-high reset.
// Ports: push/wdata in, pop/rdata out (head, show-ahead), full, empty, level.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];
    assign level   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: valid/ready fed UART transmitter with FIFO and framing.
// Ports: clk, rst (sync, active high), s_data/s_valid/s_ready stream in,
// tx line, busy, done pulse, level. Macro UART_TX_BREAK_EN adds break_req.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int      CLK_FREQ   = 50_000_000,
    parameter int      BAUD_RATE  = 115_200,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef UART_TX_BREAK_EN
    input  logic                              break_req,
`endif
    input  logic [DATA_BITS-1:0]              s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic                              tx,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CW       = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
    localparam int BW       = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(BAUD_DIV - 1);

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_stream: BAUD_DIV must be >= 2");
    end

    tx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_BITS-1:0]  sh_q, sh_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  tick;
    logic                  frame_end;
    logic                  done_c;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [DATA_BITS-1:0]  head;

`ifdef UART_TX_BREAK_EN
    localparam int FRAME_CLKS =
        frame_bits(DATA_BITS, PARITY, STOP_BITS) * BAUD_DIV;
    localparam int FW = $clog2(FRAME_CLKS + 1);
    logic          brk_q, brk_d;
    logic [FW-1:0] bcnt_q, bcnt_d;
`endif

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid && s_ready),
        .pop   (pop),
        .wdata (s_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign s_ready = !rst && !full;
    assign tick    = (cnt_q == '0);
    assign tx      = tx_q;
    assign done    = done_c;
    assign busy    = (state_q != IDLE) || (level != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? CNT_TOP : cnt_q - CW'(1);
        bit_d     = bit_q;
        stop_d    = stop_q;
        sh_d      = sh_q;
        par_d     = par_q;
        pop       = 1'b0;
        done_c    = 1'b0;
        frame_end = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_d     = brk_q;
        bcnt_d    = bcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d     = CNT_TOP;
                frame_end = 1'b1;
            end
            START: begin
                bit_d = '0;
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_BITS - 1))
                        state_d = (PARITY == PAR_NONE) ? STOP
                                                       : uart_pkg::PARITY;
                end
            end
            uart_pkg::PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        done_c    = 1'b1;
                        frame_end = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                if (!brk_q) begin
                    // Line held low; release only once a frame has elapsed.
                    cnt_d = CNT_TOP;
                    if (bcnt_q != FW'(FRAME_CLKS)) bcnt_d = bcnt_q + FW'(1);
                    if (!break_req && bcnt_q >= FW'(FRAME_CLKS - 1)) begin
                        brk_d  = 1'b1;
                        stop_d = 1'b0;
                    end
                end else if (tick) begin
                    if (stop_q == 1'(STOP_BITS - 1)) frame_end = 1'b1;
                    else                             stop_d    = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Shared decision point: idle, or last clock of a stop period.
        if (frame_end) begin
            state_d = IDLE;
`ifdef UART_TX_BREAK_EN
            if (break_req) begin
                state_d = BREAK;
                brk_d   = 1'b0;
                bcnt_d  = '0;
            end else
`endif
            if (!empty) begin
                pop     = 1'b1;
                sh_d    = head;
                par_d   = (PARITY == PAR_ODD) ? ~(^head) : ^head;
                stop_d  = 1'b0;
                state_d = START;
            end
        end
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            START:            tx_d = 1'b0;
            DATA:             tx_d = sh_q[0];
            uart_pkg::PARITY: tx_d = par_q;
`ifdef UART_TX_BREAK_EN
            BREAK:            tx_d = brk_q;
`endif
            default:          tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TX_BREAK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            brk_q  <= 1'b0;
            bcnt_q <= '0;
        end else begin
            brk_q  <= brk_d;
            bcnt_q <= bcnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed bench for uart_tx_stream.
// Covers 8N1, 8E1, 8O1, 7N2 framing, FIFO streaming, reset abort, break.
module tb_uart_tx_stream;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] s_data0;
    logic       s_valid0;
    logic       s_ready0, tx0, busy0, done0;
    logic [4:0] level0;
    logic [7:0] s_data1;
    logic [6:0] s_data3;
    logic       s_valid1;
    logic       s_ready1, tx1, busy1, done1;
    logic       s_ready2, tx2, busy2, done2;
    logic       s_ready3, tx3, busy3, done3;
    logic [4:0] level1, level2, level3;
`ifdef UART_TX_BREAK_EN
    logic       break0;
    logic       break_off;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_stream #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000))
    u0 (.clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
        .break_req(break0),
`endif
        .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
        .tx(tx0), .busy(busy0), .done(done0), .level(level0));

    uart_tx_stream #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                     .PARITY(PAR_EVEN))
    u1 (.clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
        .break_req(break_off),
`endif
        .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .tx(tx1), .busy(busy1), .done(done1), .level(level1));

    uart_tx_stream #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                     .PARITY(PAR_ODD))
    u2 (.clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
        .break_req(break_off),
`endif
        .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready2),
        .tx(tx2), .busy(busy2), .done(done2), .level(level2));

    uart_tx_stream #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                     .DATA_BITS(7), .STOP_BITS(2))
    u3 (.clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
        .break_req(break_off),
`endif
        .s_data(s_data3), .s_valid(s_valid1), .s_ready(s_ready3),
        .tx(tx3), .busy(busy3), .done(done3), .level(level3));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles after the handshake edge (BAUD_DIV=10).
    function automatic logic exp_tx(input int k, input logic [8:0] d,
                                    input int nb, input int has_par,
                                    input logic pbit);
        int b;
        if (k < 2) return 1'b1;
        b = (k - 2) / 10;
        if (b == 0) return 1'b0;
        if (b <= nb) return d[b-1];
        if (has_par != 0 && b == nb + 1) return pbit;
        return 1'b1;
    endfunction

    logic       txa [0:399];
    logic       tya [0:399];
    logic       tza [0:399];
    logic       dna [0:399];
    logic       dya [0:399];
    logic       dza [0:399];
    logic       bsa [0:399];
    logic [7:0] b16 [0:16];
    logic [7:0] rxq [0:19];
    int         starts [0:19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dn, di, dn2, di2, dn3, di3;
        int  p, cyc, rxn, rc, badrdy, badstop, lowcnt;
        logic hs, rxon, sawfull;
        logic [7:0] rxb;

        for (int i = 0; i < 16; i++)
            b16[i] = (i == 15) ? 8'h00 : 8'(8'h11 * (i + 1));
        b16[16]  = 8'h00;
        rst      = 1'b1;
        s_valid0 = 1'b0;
        s_data0  = 8'h00;
        s_valid1 = 1'b0;
        s_data1  = 8'h00;
        s_data3  = 7'h00;
`ifdef UART_TX_BREAK_EN
        break0    = 1'b0;
        break_off = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_level", level0, 0);
        chk("rst_ready", s_ready0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", s_ready0, 1);
        chk("rel_tx", tx0, 1);
        chk("rel_busy", busy0, 0);

        // Single 8N1 frame of A5
        s_data0  = 8'hA5;
        s_valid0 = 1'b1;
        @(negedge clk);
        s_valid0 = 1'b0;
        chk("t1_level", level0, 1);
        chk("t1_busy0", busy0, 1);
        for (int k = 1; k <= 102; k++) begin
            @(negedge clk);
            txa[k] = tx0;
            dna[k] = done0;
            bsa[k] = busy0;
        end
        dn = 0;
        di = 0;
        for (int k = 1; k <= 102; k++) begin
            chk($sformatf("t1_tx_k%0d", k), txa[k],
                exp_tx(k, 9'h0A5, 8, 0, 1'b0));
            if (dna[k]) begin
                dn++;
                di = k;
            end
        end
        chk("t1_done_cnt", dn, 1);
        chk("t1_done_at", di, 100);
        chk("t1_busy_100", bsa[100], 1);
        chk("t1_busy_101", bsa[101], 0);

        // 8E1 / 8O1 with 07, 7N2 with 55
        s_data1  = 8'h07;
        s_data3  = 7'h55;
        s_valid1 = 1'b1;
        @(negedge clk);
        s_valid1 = 1'b0;
        for (int k = 1; k <= 115; k++) begin
            @(negedge clk);
            txa[k] = tx1;
            tya[k] = tx2;
            tza[k] = tx3;
            dna[k] = done1;
            dya[k] = done2;
            dza[k] = done3;
        end
        dn = 0; di = 0; dn2 = 0; di2 = 0; dn3 = 0; di3 = 0;
        for (int k = 1; k <= 115; k++) begin
            chk($sformatf("t3_even_k%0d", k), txa[k],
                exp_tx(k, 9'h007, 8, 1, 1'b1));
            chk($sformatf("t3_odd_k%0d", k), tya[k],
                exp_tx(k, 9'h007, 8, 1, 1'b0));
            chk($sformatf("t3_7n2_k%0d", k), tza[k],
                exp_tx(k, 9'h055, 7, 0, 1'b0));
            if (dna[k]) begin dn++;  di = k;  end
            if (dya[k]) begin dn2++; di2 = k; end
            if (dza[k]) begin dn3++; di3 = k; end
        end
        chk("t3_even_done_cnt", dn, 1);
        chk("t3_even_done_at", di, 110);
        chk("t3_odd_done_cnt", dn2, 1);
        chk("t3_odd_done_at", di2, 110);
        chk("t3_7n2_done_cnt", dn3, 1);
        chk("t3_7n2_done_at", di3, 100);
        chk("t3_7n2_idle", busy3, 0);

        // C3 then 16 back-to-back bytes through the FIFO
        s_data0  = 8'hC3;
        s_valid0 = 1'b1;
        @(negedge clk);
        s_valid0 = 1'b0;
        p = 0; cyc = 0; rxn = 0; rc = 0; dn = 0;
        badrdy = 0; badstop = 0;
        rxon = 1'b0; sawfull = 1'b0; rxb = 8'h00;
        while (cyc < 2200) begin
            s_valid0 = (p < 16);
            s_data0  = b16[p];
            hs = s_valid0 && s_ready0;
            if (s_ready0 !== (level0 != 5'd16)) badrdy++;
            if (level0 == 5'd16) sawfull = 1'b1;
            @(negedge clk);
            cyc++;
            if (hs) p++;
            if (done0) dn++;
            if (!rxon) begin
                if (tx0 == 1'b0) begin
                    rxon = 1'b1;
                    rc   = 0;
                    if (rxn < 20) starts[rxn] = cyc;
                end
            end else begin
                rc++;
                if (rc >= 15 && rc <= 85 && (rc % 10) == 5)
                    rxb[(rc-15)/10] = tx0;
                if (rc == 95 && tx0 !== 1'b1) badstop++;
                if (rc == 99) begin
                    if (rxn < 20) rxq[rxn] = rxb;
                    rxn++;
                    rxon = 1'b0;
                end
            end
            if (p == 16 && !busy0) break;
        end
        s_valid0 = 1'b0;
        chk("t2_finished", (p == 16 && !busy0), 1);
        chk("t2_rx_count", rxn, 17);
        chk("t2_done_cnt", dn, 17);
        chk("t2_saw_full", sawfull, 1);
        chk("t2_ready_rule", badrdy, 0);
        chk("t2_stop_bits", badstop, 0);
        chk("t2_byte0", rxq[0], 8'hC3);
        for (int i = 1; i < 17 && i < rxn; i++) begin
            chk($sformatf("t2_byte%0d", i), rxq[i], b16[i-1]);
            chk($sformatf("t2_gap%0d", i), starts[i] - starts[i-1], 100);
        end

        // Reset at cycle 35 of a frame with 3 more bytes queued
        for (int i = 0; i < 4; i++) begin
            s_data0  = 8'h5A ^ 8'(i);
            s_valid0 = 1'b1;
            @(negedge clk);
        end
        s_valid0 = 1'b0;
        chk("t4_level", level0, 3);
        dn = 0;
        for (int k = 4; k <= 35; k++) begin
            @(negedge clk);
            if (done0) dn++;
        end
        chk("t4_midframe_tx", tx0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_tx", tx0, 1);
        chk("t4_rst_level", level0, 0);
        chk("t4_rst_busy", busy0, 0);
        chk("t4_rst_ready", s_ready0, 0);
        chk("t4_rst_done", done0, 0);
        @(negedge clk);
        rst = 1'b0;
        lowcnt = 0;
        di = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) lowcnt++;
            if (done0) dn++;
            if (busy0) di++;
        end
        chk("t4_no_tx", lowcnt, 0);
        chk("t4_no_done", dn, 0);
        chk("t4_no_busy", di, 0);

`ifdef UART_TX_BREAK_EN
        // Break for 150 cycles with one byte queued
        break0   = 1'b1;
        s_data0  = 8'h3C;
        s_valid0 = 1'b1;
        @(negedge clk);
        s_valid0 = 1'b0;
        for (int k = 1; k <= 262; k++) begin
            @(negedge clk);
            txa[k] = tx0;
            dna[k] = done0;
            if (k == 149) break0 = 1'b0;
        end
        lowcnt = 0;
        for (int k = 1; k <= 150; k++)
            if (txa[k] !== 1'b0) lowcnt++;
        chk("t5_break_low", lowcnt, 0);
        lowcnt = 0;
        for (int k = 151; k <= 160; k++)
            if (txa[k] !== 1'b1) lowcnt++;
        chk("t5_break_stop", lowcnt, 0);
        dn = 0;
        di = 0;
        for (int k = 1; k <= 262; k++) begin
            if (dna[k]) begin dn++; di = k; end
            if (k >= 161)
                chk($sformatf("t5_tx_k%0d", k), txa[k],
                    exp_tx(k - 159, 9'h03C, 8, 0, 1'b0));
        end
        chk("t5_done_cnt", dn, 1);
        chk("t5_done_at", di, 259);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Parametrised, synthesizable UART transmitter.
- Successor to the fixed-pattern simulation transmitter: payload arrives over a valid/ready stream into an internal FIFO and is serialised with configurable frame format (data bits, parity, stop bits).
- Sits between the AES output datapath and the board TX pin.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate; BAUD_DIV = CLK_FREQ/BAUD_RATE (truncated), must be >= 2, otherwise $error at elaboration
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, PAR_NONE, parity_e from uart_pkg: PAR_NONE, PAR_EVEN, PAR_ODD
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_data  in  DATA_BITS  byte to send
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; transfer on s_valid && s_ready at rising clk
tx  out  1  serial line, idle high
busy  out  1  frame in progress or FIFO non-empty
done  out  1  one-cycle pulse at end of each frame's last stop bit
level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- One clock, synchronous active-high reset. While rst is high, at each edge:
  - tx=1, busy=0, done=0, level=0, s_ready=0.
  - FIFO emptied, FSM to IDLE, baud counter cleared.
- Reset asserted mid-frame aborts the frame; tx is high after that edge and no done pulse is emitted.
- FIFO write: on handshake, s_data is stored and level increments.
- s_ready = !rst && (level < FIFO_DEPTH). A full FIFO never accepts, even when popping in the same cycle.
- Simultaneous push and pop: level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If FIFO non-empty: pop head into shift register, load baud counter with BAUD_DIV-1, go to START.
  - Start bit (tx=0) is visible from the edge after the pop.
  - Handshake at edge N into an empty idle block: pop at edge N+1, tx low after edge N+2.
- Bit timing: every bit (start, data, parity, stop) lasts exactly BAUD_DIV clocks. The counter decrements and the state advances when it reaches 0.
- DATA: LSB first, DATA_BITS bits; bit counter width $clog2(DATA_BITS+1).
- PARITY: state skipped when PAR_NONE.
  - PAR_EVEN: bit = XOR of data.
  - PAR_ODD: bit = inverted XOR of data.
  - Parity is computed at pop time.
- STOP: tx=1 for STOP_BITS bit times. On the final clock of the last stop bit:
  - done=1 for that cycle.
  - If FIFO non-empty: pop and go directly to START, giving zero idle gap (back-to-back frames).
  - Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + parity? + STOP_BITS) * BAUD_DIV clocks.
- busy = (state != IDLE) || (level != 0). tx is driven from a register (glitch-free).

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined:
  - Adds input port break_req (1 bit) and state BREAK.
  - break_req sampled in IDLE, or at the end-of-frame decision point, takes priority over a FIFO pop.
  - Enters BREAK: tx=0 while break_req high (minimum one full frame length), then tx=1 for STOP_BITS bit times before returning to IDLE.
  - FIFO continues accepting during break.
- Undefined: no break_req port, no BREAK state; behaviour exactly as above.

Decomposition:
- uart_pkg holds:
  - parity_e enum
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - function baud_div(clk_freq, baud_rate)
  - frame_bits(data_bits, parity, stop_bits) helper
- Sub-module uart_tx_fifo: synchronous FIFO with parameters WIDTH and DEPTH; ports push, pop, wdata, rdata, full, empty, level; rst synchronous active-high.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BAUD_DIV=10):
- Single byte 8'hA5, 8N1, idle block -> tx low 2 cycles after handshake; bits 1,0,1,0,0,1,0,1 each 10 cycles; stop high 10 cycles; done pulses once at cycle 100 of the frame; busy falls the next cycle.
- Push 8'h11..8'h00 (16 bytes) back-to-back into FIFO_DEPTH=16 -> s_ready low exactly while level=16; 16 frames with no idle gap; received bytes match in order; done pulses 16 times.
- PARITY=PAR_EVEN, 8'h07 -> parity bit 1. PARITY=PAR_ODD, 8'h07 -> parity bit 0. Frame length 110 cycles.
- DATA_BITS=7, STOP_BITS=2, 7'h55 -> 7 data bits LSB first, stop high 20 cycles, frame 100 cycles.
- Assert rst at cycle 35 of a frame with 3 bytes queued -> tx=1, level=0, busy=0, s_ready=0 after that edge; no done pulse; no further frames after release.
- (UART_TX_BREAK_EN) break_req high for 150 cycles while idle -> tx low for 150 cycles, then high 10 cycles, then the queued byte transmits.
